// File: rtl/trap_sequencer_if.sv
// Bundles the control-unit side of the trap sequencer. The control unit
// drives requests and hazard information and reads back the sequence strobes.
interface trap_sequencer_if #(
    parameter int N_EXC = 4,
    parameter int N_IRQ = 3,
    parameter int VEC_W = 4
);
    logic             stall;
    logic [N_EXC-1:0] exc_req;
    logic [N_IRQ-1:0] irq_req;
    logic             irq_en;
    logic             rti;

    logic             busy;
    logic [1:0]       trap_kind;
    logic [VEC_W-1:0] vec_sel;
    logic             flush;
    logic             push_pc;
    logic             push_flags;
    logic             load_vec;
    logic             in_service;
    logic [N_EXC-1:0] exc_pending;
    logic [N_IRQ-1:0] irq_pending;

    modport master (
        output stall, exc_req, irq_req, irq_en, rti,
        input  busy, trap_kind, vec_sel, flush, push_pc, push_flags,
               load_vec, in_service, exc_pending, irq_pending
    );

    modport slave (
        input  stall, exc_req, irq_req, irq_en, rti,
        output busy, trap_kind, vec_sel, flush, push_pc, push_flags,
               load_vec, in_service, exc_pending, irq_pending
    );
endinterface

// File: rtl/trap_sequencer.sv
// Trap and interrupt sequencer. Latches exception and interrupt requests,
// arbitrates them by fixed priority (lowest index first, exceptions before
// interrupts) and walks the flush / push / vector-load sequence one strobe
// per cycle. A stall holds the current step and suppresses its strobe.
module trap_sequencer #(
    parameter int N_EXC = 4,
    parameter int N_IRQ = 3,
    parameter int VEC_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        RST_VEC    = 3'd0,
        IDLE       = 3'd1,
        FLUSH      = 3'd2,
        PUSH_PC    = 3'd3,
        PUSH_FLAGS = 3'd4,
        LOAD_VEC   = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [N_EXC-1:0] exc_pending_r;
    logic [N_IRQ-1:0] irq_pending_r;
    logic [N_IRQ-1:0] irq_q_r;
    logic             in_service_r;
    logic [1:0]       kind_r;
    logic [VEC_W-1:0] vec_r;

    logic [N_EXC-1:0] exc_onehot_s;
    logic [VEC_W-1:0] exc_vec_s;
    logic [N_IRQ-1:0] irq_onehot_s;
    logic [VEC_W-1:0] irq_vec_s;
    logic             idle_go_s;
    logic             grant_exc_s;
    logic             grant_irq_s;
    logic [N_EXC-1:0] exc_clr_s;
    logic [N_IRQ-1:0] irq_clr_s;
    logic             busy_s;
    logic             flush_s;
    logic             push_pc_s;
    logic             push_flags_s;
    logic             load_vec_s;

    // Lowest-index pending request of each class and its vector number.
    always_comb begin
        exc_onehot_s = {N_EXC{1'b0}};
        exc_vec_s    = {VEC_W{1'b0}};
        irq_onehot_s = {N_IRQ{1'b0}};
        irq_vec_s    = {VEC_W{1'b0}};
        for (int i = N_EXC - 1; i >= 0; i--) begin
            exc_onehot_s = exc_pending_r[i] ? ({{(N_EXC-1){1'b0}}, 1'b1} << i) : exc_onehot_s;
            exc_vec_s    = exc_pending_r[i] ? VEC_W'(i + 1) : exc_vec_s;
        end
        for (int j = N_IRQ - 1; j >= 0; j--) begin
            irq_onehot_s = irq_pending_r[j] ? ({{(N_IRQ-1){1'b0}}, 1'b1} << j) : irq_onehot_s;
            irq_vec_s    = irq_pending_r[j] ? VEC_W'(j + 1 + N_EXC) : irq_vec_s;
        end
    end

    // Grants only fire from an unstalled IDLE; exceptions ignore masking.
    assign idle_go_s   = (state_r == IDLE) && !bus.stall;
    assign grant_exc_s = idle_go_s && (|exc_pending_r);
    assign grant_irq_s = idle_go_s && !(|exc_pending_r) && bus.irq_en
                         && !in_service_r && (|irq_pending_r);
    assign exc_clr_s   = grant_exc_s ? exc_onehot_s : {N_EXC{1'b0}};
    assign irq_clr_s   = grant_irq_s ? irq_onehot_s : {N_IRQ{1'b0}};

    // Next-state selection and Moore strobe decode; stall gates every strobe.
    always_comb begin
        state_next_s = state_r;
        busy_s       = 1'b1;
        flush_s      = 1'b0;
        push_pc_s    = 1'b0;
        push_flags_s = 1'b0;
        load_vec_s   = 1'b0;
        case (state_r)
            RST_VEC: begin
                load_vec_s = !bus.stall;
                if (!bus.stall) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RST_VEC;
                end
            end
            IDLE: begin
                busy_s = 1'b0;
                if (grant_exc_s || grant_irq_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FLUSH: begin
                flush_s = !bus.stall;
                if (!bus.stall) begin
                    state_next_s = PUSH_PC;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            PUSH_PC: begin
                push_pc_s = !bus.stall;
                if (bus.stall) begin
                    state_next_s = PUSH_PC;
                end else if (kind_r == 2'b11) begin
                    state_next_s = PUSH_FLAGS;
                end else begin
                    state_next_s = LOAD_VEC;
                end
            end
            PUSH_FLAGS: begin
                push_flags_s = !bus.stall;
                if (!bus.stall) begin
                    state_next_s = LOAD_VEC;
                end else begin
                    state_next_s = PUSH_FLAGS;
                end
            end
            LOAD_VEC: begin
                load_vec_s = !bus.stall;
                if (!bus.stall) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOAD_VEC;
                end
            end
            default: begin
                state_next_s = RST_VEC;
            end
        endcase
    end

    // Sequence state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RST_VEC;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Trap kind and vector: captured at grant, cleared on return to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind_r <= 2'b01;
            vec_r  <= {VEC_W{1'b0}};
        end else if (grant_exc_s) begin
            kind_r <= 2'b10;
            vec_r  <= exc_vec_s;
        end else if (grant_irq_s) begin
            kind_r <= 2'b11;
            vec_r  <= irq_vec_s;
        end else if ((state_next_s == IDLE) && (state_r != IDLE)) begin
            kind_r <= 2'b00;
            vec_r  <= {VEC_W{1'b0}};
        end else begin
            kind_r <= kind_r;
            vec_r  <= vec_r;
        end
    end

    // Pending latches and irq edge detect; a new request beats a same-edge clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_pending_r <= {N_EXC{1'b0}};
            irq_pending_r <= {N_IRQ{1'b0}};
            irq_q_r       <= {N_IRQ{1'b0}};
        end else begin
            exc_pending_r <= (exc_pending_r & ~exc_clr_s) | bus.exc_req;
            irq_pending_r <= (irq_pending_r & ~irq_clr_s) | (bus.irq_req & ~irq_q_r);
            irq_q_r       <= bus.irq_req;
        end
    end

    // In-service flag: an interrupt grant sets it and beats a same-edge rti.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_service_r <= 1'b0;
        end else begin
            in_service_r <= grant_irq_s | (in_service_r & ~bus.rti);
        end
    end

    assign bus.busy        = busy_s;
    assign bus.trap_kind   = kind_r;
    assign bus.vec_sel     = vec_r;
    assign bus.flush       = flush_s;
    assign bus.push_pc     = push_pc_s;
    assign bus.push_flags  = push_flags_s;
    assign bus.load_vec    = load_vec_s;
    assign bus.in_service  = in_service_r;
    assign bus.exc_pending = exc_pending_r;
    assign bus.irq_pending = irq_pending_r;

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Parametrised trap and interrupt sequencer that sits beside the control unit in the decode stage. It latches pending exceptions and interrupts, arbitrates them by fixed priority, and runs a multi-cycle trap sequence (flush, push PC, push flags, load vector) as one-cycle strobes that the control unit merges into its signal word. It generalises the fixed reset/exception/interrupt cases to N_EXC exception sources and N_IRQ interrupt lines. It adds pending latches, masking, in-service tracking and hazard-stall freezing.

## Interface
- N_EXC, default 4: number of exception sources; index 0 has the highest priority.
- N_IRQ, default 3: number of interrupt lines; index 0 has the highest priority.
- VEC_W, default 4: vector index width; 2^VEC_W >= 1+N_EXC+N_IRQ is required.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  control hazard; freezes sequence advance.
- exc_req  in  N_EXC  one-cycle exception request pulses.
- irq_req  in  N_IRQ  interrupt lines, rising-edge sensitive.
- irq_en  in  1  global interrupt enable.
- rti  in  1  return-from-interrupt pulse; clears in_service.
- busy  out  1  high in every state except IDLE.
- trap_kind  out  2  current trap: 00 none, 01 reset, 10 exception, 11 interrupt.
- vec_sel  out  VEC_W  vector index of the current trap.
- flush, push_pc, push_flags, load_vec  out  1 each  sequence strobes.
- in_service  out  1  an interrupt handler is active.
- exc_pending  out  N_EXC  latched exception requests.
- irq_pending  out  N_IRQ  latched interrupt requests.

## Operation
- States: RST_VEC, IDLE, FLUSH, PUSH_PC, PUSH_FLAGS, LOAD_VEC. Outputs are Moore-decoded from the state register.
- Vector map:
  - reset = 0
  - exception i = 1+i
  - interrupt j = 1+N_EXC+j
  - vec_sel and trap_kind are registered at grant and held until return to IDLE.
- Pending capture runs every cycle, in every state and during stall:
  - exc_pending |= exc_req.
  - irq_pending |= irq_req & ~irq_q, where irq_q is irq_req delayed one cycle.
- Grant happens only in IDLE with stall=0:
  - If any exc_pending bit is set, take the lowest index, clear that bit, set trap_kind=10, and go to FLUSH.
  - Otherwise, if irq_en=1, in_service=0 and any irq_pending bit is set, take the lowest index, clear that bit, set trap_kind=11, set in_service, and go to FLUSH.
  - Exceptions are granted regardless of in_service or irq_en.
- Sequence paths:
  - Exception: FLUSH -> PUSH_PC -> LOAD_VEC -> IDLE.
  - Interrupt: FLUSH -> PUSH_PC -> PUSH_FLAGS -> LOAD_VEC -> IDLE.
- RST_VEC: trap_kind=01, vec_sel=0, load_vec=1; goes to IDLE on the first edge with stall=0.
- Strobes: each strobe is high only in its own state AND stall=0. A stalled state is held and its strobe stays low until stall drops.
- rti clears in_service on the edge. If a grant sets in_service on the same edge, the set wins.
- Same-cycle new request on the bit being granted: the set wins and the bit stays pending.
- Masked interrupts (irq_en=0) remain pending indefinitely.
- Arbitration is not re-run mid-sequence. A higher-priority arrival waits for IDLE.

## Timing
- Reset asserted, asynchronously:
  - state=RST_VEC, so busy=1, trap_kind=01, vec_sel=0, load_vec=1.
  - Other strobes 0.
  - exc_pending, irq_pending, irq_q and in_service are all 0.
- Reset released: IDLE one edge later if stall=0.
- irq_q resets to 0, so a line held high through reset registers as an edge on the first clock after release.
- Exception latency: request sampled at edge E0 (pending visible after E0).
  - E1 grants (FLUSH).
  - push_pc after E2.
  - load_vec after E3.
  - IDLE after E4.
- Interrupt latency: E0 edge detect.
  - FLUSH after E1.
  - PUSH_PC after E2.
  - PUSH_FLAGS after E3.
  - LOAD_VEC after E4.
  - IDLE after E5.
- Back-to-back: the next grant can occur on the edge leaving LOAD_VEC+1, i.e. IDLE lasts at least one cycle.
- Each stall cycle adds exactly one cycle to the current state.
- Reset mid-sequence: returns immediately to RST_VEC with all pending and in-service state cleared.

## Test plan
- Reset release, stall=0: during reset load_vec=1, vec_sel=0, trap_kind=01. One edge after release: busy=0, all strobes 0.
- exc_req=4'b0101 pulse in IDLE:
  - Bit 0 is granted first, vec_sel=1, strobe order flush, push_pc, load_vec.
  - After return, bit 2 is granted with vec_sel=3.
  - Never push_flags.
- irq_req[1] rises, irq_en=1:
  - vec_sel=6, strobes flush, push_pc, push_flags, load_vec on consecutive cycles.
  - in_service=1 until rti.
  - A second irq edge meanwhile stays pending and is granted one cycle after rti returns to IDLE.
- irq_en=0 with irq_req[0] rising: irq_pending[0]=1, no grant. Raising irq_en grants it, vec_sel=5.
- stall held 2 cycles while in PUSH_PC: push_pc low during the stall, high in the first non-stall cycle. Total sequence lengthened by 2.
- exc_req[3] and irq_req[2] in the same cycle: the exception (vec_sel=4) runs first, then the interrupt (vec_sel=7). Reset asserted mid-interrupt returns to RST_VEC and clears all pending bits.
